// File: rtl/regfile_wb.sv
// Writeback stage for the register file's single write port.
// It arbitrates between the execute and load result channels and registers
// the winning result onto the write port. It also keeps a per-register
// pending scoreboard, and one cycle later re-presents each write as a bypass
// entry, because the register file's registered read returns stale data for
// a write made in the same cycle.
module regfile_wb #(
  parameter int XW = 32,
  parameter int CW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ex_valid,
  output logic          o_ex_ready,
  input  logic [4:0]    i_ex_rd,
  input  logic [XW-1:0] i_ex_data,
  input  logic          i_ld_valid,
  output logic          o_ld_ready,
  input  logic [4:0]    i_ld_rd,
  input  logic [XW-1:0] i_ld_data,
  input  logic          i_issue_valid,
  input  logic [4:0]    i_issue_rd,
  output logic [31:0]   o_busy,
  output logic          o_wr_en,
  output logic [4:0]    o_wr_addr,
  output logic [XW-1:0] o_wr_data,
  output logic          o_byp_valid,
  output logic [4:0]    o_byp_addr,
  output logic [XW-1:0] o_byp_data,
  output logic [CW-1:0] o_retire_cnt
);

  typedef enum logic {SRC_EX = 1'b0, SRC_LD = 1'b1} src_e;

  src_e          last_grant;
  logic          grant_ex;
  logic          grant_ld;
  logic          contended;
  logic          hs_p0;
  logic [4:0]    rd_p0;
  logic [XW-1:0] data_p0;
  logic [31:0]   busy_nxt;

  logic          wr_vld_p1;
  logic [4:0]    wr_addr_p1;
  logic [XW-1:0] wr_data_p1;
  logic          byp_vld_p2;
  logic [4:0]    byp_addr_p2;
  logic [XW-1:0] byp_data_p2;
  logic [31:0]   busy_q;
  logic [CW-1:0] retire_q;

  // Round-robin grant on contention; a lone valid channel always wins.
  always_comb begin
    grant_ex  = 1'b0;
    grant_ld  = 1'b0;
    contended = i_ex_valid & i_ld_valid;
    if (contended) begin
      if (last_grant == SRC_EX) grant_ld = 1'b1;
      else                      grant_ex = 1'b1;
    end else begin
      grant_ex = i_ex_valid;
      grant_ld = i_ld_valid;
    end
  end

  // Selected result for this cycle's handshake.
  always_comb begin
    hs_p0   = grant_ex | grant_ld;
    rd_p0   = grant_ld ? i_ld_rd   : i_ex_rd;
    data_p0 = grant_ld ? i_ld_data : i_ex_data;
  end

  // Scoreboard next state: clear on retire, then set on issue so a newer
  // pending instruction wins; x0 never waits on anything.
  always_comb begin
    busy_nxt = busy_q;
    if (hs_p0)         busy_nxt[rd_p0]      = 1'b0;
    if (i_issue_valid) busy_nxt[i_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Control state: arbitration history, scoreboard and retire counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant <= SRC_EX;
      busy_q     <= '0;
      retire_q   <= '0;
    end else begin
      if (contended) last_grant <= grant_ld ? SRC_LD : SRC_EX;
      busy_q <= busy_nxt;
      if (hs_p0) retire_q <= retire_q + CW'(1);
    end
  end

  // Stage p0 -> p1: register the accepted result onto the write port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_vld_p1 <= hs_p0 & (rd_p0 != 5'd0);
      if (hs_p0) begin
        wr_addr_p1 <= rd_p0;
        wr_data_p1 <= data_p0;
      end
    end
  end

  // Stage p1 -> p2: the write that landed last cycle becomes the bypass entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byp_vld_p2  <= 1'b0;
      byp_addr_p2 <= '0;
      byp_data_p2 <= '0;
    end else begin
      byp_vld_p2  <= wr_vld_p1;
      byp_addr_p2 <= wr_addr_p1;
      byp_data_p2 <= wr_data_p1;
    end
  end

  assign o_ex_ready   = grant_ex;
  assign o_ld_ready   = grant_ld;
  assign o_busy       = busy_q;
  assign o_wr_en      = wr_vld_p1;
  assign o_wr_addr    = wr_addr_p1;
  assign o_wr_data    = wr_data_p1;
  assign o_byp_valid  = byp_vld_p2;
  assign o_byp_addr   = byp_addr_p2;
  assign o_byp_data   = byp_data_p2;
  assign o_retire_cnt = retire_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Testbench for regfile_wb: directed scenarios followed by random traffic,
// all checked against a behavioural model of the writeback rules.
module tb_regfile_wb;
  localparam int XW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          ex_valid = 1'b0, ld_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0]    ex_rd = '0, ld_rd = '0, issue_rd = '0;
  logic [XW-1:0] ex_data = '0, ld_data = '0;

  logic          ex_ready, ld_ready, wr_en, byp_valid;
  logic [31:0]   busy;
  logic [4:0]    wr_addr, byp_addr;
  logic [XW-1:0] wr_data, byp_data;
  logic [31:0]   retire_cnt;

  logic          ex_ready4, ld_ready4, wr_en4, byp_valid4;
  logic [31:0]   busy4;
  logic [4:0]    wr_addr4, byp_addr4;
  logic [XW-1:0] wr_data4, byp_data4;
  logic [3:0]    retire_cnt4;

  regfile_wb #(.XW(XW), .CW(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ex_valid(ex_valid), .o_ex_ready(ex_ready), .i_ex_rd(ex_rd), .i_ex_data(ex_data),
    .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_rd(ld_rd), .i_ld_data(ld_data),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd), .o_busy(busy),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_byp_valid(byp_valid), .o_byp_addr(byp_addr), .o_byp_data(byp_data),
    .o_retire_cnt(retire_cnt)
  );

  regfile_wb #(.XW(XW), .CW(4)) dut4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ex_valid(ex_valid), .o_ex_ready(ex_ready4), .i_ex_rd(ex_rd), .i_ex_data(ex_data),
    .i_ld_valid(ld_valid), .o_ld_ready(ld_ready4), .i_ld_rd(ld_rd), .i_ld_data(ld_data),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd), .o_busy(busy4),
    .o_wr_en(wr_en4), .o_wr_addr(wr_addr4), .o_wr_data(wr_data4),
    .o_byp_valid(byp_valid4), .o_byp_addr(byp_addr4), .o_byp_data(byp_data4),
    .o_retire_cnt(retire_cnt4)
  );

  always #5 i_clk = ~i_clk;

  int nvec = 0;
  int nmiss = 0;

  // Reference model state
  bit            m_prefer_ld;   // next contended cycle goes to load
  bit            m_wr_en, m_byp_valid;
  logic [4:0]    m_wr_addr, m_byp_addr;
  logic [XW-1:0] m_wr_data, m_byp_data;
  bit            m_busy [32];
  int unsigned   m_count;
  bit            last_ex_hs, last_ld_hs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmiss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic model_reset();
    m_prefer_ld = 1'b1;
    m_wr_en = 0; m_byp_valid = 0;
    m_wr_addr = '0; m_byp_addr = '0; m_wr_data = '0; m_byp_data = '0;
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
    m_count = 0;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_wr_en"},     64'(wr_en),       64'(m_wr_en));
    chk({pfx, "_wr_addr"},   64'(wr_addr),     64'(m_wr_addr));
    chk({pfx, "_wr_data"},   64'(wr_data),     64'(m_wr_data));
    chk({pfx, "_byp_valid"}, 64'(byp_valid),   64'(m_byp_valid));
    chk({pfx, "_byp_addr"},  64'(byp_addr),    64'(m_byp_addr));
    chk({pfx, "_byp_data"},  64'(byp_data),    64'(m_byp_data));
    chk({pfx, "_busy"},      64'(busy),        64'(m_busy_vec()));
    chk({pfx, "_cnt"},       64'(retire_cnt),  64'(m_count));
    chk({pfx, "_cnt4"},      64'(retire_cnt4), 64'(m_count % 16));
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic step(input string pfx);
    bit g_ex, g_ld, hs;
    logic [4:0] rd;
    logic [XW-1:0] d;
    #1;
    g_ex = 0; g_ld = 0;
    if (ex_valid && ld_valid) begin
      if (m_prefer_ld) g_ld = 1; else g_ex = 1;
    end else begin
      g_ex = ex_valid; g_ld = ld_valid;
    end
    chk({pfx, "_ex_ready"}, 64'(ex_ready), 64'(g_ex));
    chk({pfx, "_ld_ready"}, 64'(ld_ready), 64'(g_ld));
    hs = g_ex || g_ld;
    rd = g_ld ? ld_rd : ex_rd;
    d  = g_ld ? ld_data : ex_data;
    last_ex_hs = g_ex;
    last_ld_hs = g_ld;
    @(posedge i_clk);
    m_byp_valid = m_wr_en; m_byp_addr = m_wr_addr; m_byp_data = m_wr_data;
    m_wr_en = hs && (rd != 0);
    if (hs) begin
      m_wr_addr = rd; m_wr_data = d;
      m_busy[rd] = 0;
      m_count++;
    end
    if (issue_valid) m_busy[issue_rd] = 1;
    m_busy[0] = 0;
    if (ex_valid && ld_valid) m_prefer_ld = g_ex;
    #1;
    check_outputs(pfx);
  endtask

  task automatic idle();
    ex_valid = 0; ld_valid = 0; issue_valid = 0;
  endtask

  task automatic do_reset(input string pfx);
    idle();
    i_rst_n = 0;
    model_reset();
    @(negedge i_clk);
    check_outputs(pfx);
    i_rst_n = 1;
  endtask

  logic [4:0] exp_addr_seq [4];

  initial begin
    model_reset();
    do_reset("rst");

    // Single execute result
    ex_valid = 1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
    step("single");
    chk("single_addr", 64'(wr_addr), 64'd5);
    chk("single_data", 64'(wr_data), 64'hDEADBEEF);
    idle();
    step("single_byp");
    chk("single_byp_valid", 64'(byp_valid), 64'd1);
    chk("single_byp_addr",  64'(byp_addr),  64'd5);
    chk("single_cnt",       64'(retire_cnt), 64'd1);

    // Contention from reset: load, execute, load, execute
    do_reset("rst2");
    exp_addr_seq[0] = 5'd3; exp_addr_seq[1] = 5'd4;
    exp_addr_seq[2] = 5'd3; exp_addr_seq[3] = 5'd4;
    ex_valid = 1; ex_rd = 5'd4; ex_data = 32'h4444_0000;
    ld_valid = 1; ld_rd = 5'd3; ld_data = 32'h3333_0000;
    for (int i = 0; i < 4; i++) begin
      step("contend");
      chk("contend_one_ready", 64'(last_ex_hs && last_ld_hs), 64'd0);
      chk("contend_addr", 64'(wr_addr), 64'(exp_addr_seq[i]));
    end
    idle();

    // Write to x0: accepted and counted, never written
    ex_valid = 1; ex_rd = 5'd0; ex_data = 32'h1234;
    step("x0");
    chk("x0_wr_en", 64'(wr_en), 64'd0);
    chk("x0_busy0", 64'(busy[0]), 64'd0);
    chk("x0_cnt",   64'(retire_cnt), 64'd5);
    idle();

    // Scoreboard: set, set-beats-clear, clear
    issue_valid = 1; issue_rd = 5'd7;
    step("sb_set");
    chk("sb_set_b7", 64'(busy[7]), 64'd1);
    ex_valid = 1; ex_rd = 5'd7; ex_data = 32'h77;
    step("sb_both");
    chk("sb_both_b7", 64'(busy[7]), 64'd1);
    issue_valid = 0;
    step("sb_clr");
    chk("sb_clr_b7", 64'(busy[7]), 64'd0);
    idle();

    // Counter wrap on the 4-bit instance
    do_reset("rst3");
    ex_valid = 1; ex_rd = 5'd9;
    for (int i = 0; i < 17; i++) begin
      ex_data = 32'(i);
      step("wrap");
    end
    chk("wrap_cnt4", 64'(retire_cnt4), 64'd1);
    chk("wrap_cnt32", 64'(retire_cnt), 64'd17);
    idle();

    // Asynchronous reset while a write is on the port and x7 is pending
    do_reset("rst4");
    issue_valid = 1; issue_rd = 5'd7;
    step("ar_issue");
    issue_valid = 0;
    ex_valid = 1; ex_rd = 5'd5; ex_data = 32'hCAFE;
    step("ar_write");
    chk("ar_pre_wr_en", 64'(wr_en), 64'd1);
    chk("ar_pre_busy",  64'(busy), 64'h80);
    #2;
    i_rst_n = 0;
    #1;
    chk("ar_wr_en",  64'(wr_en), 64'd0);
    chk("ar_busy",   64'(busy), 64'd0);
    chk("ar_cnt",    64'(retire_cnt), 64'd0);
    chk("ar_byp",    64'(byp_valid), 64'd0);
    chk("ar_addr",   64'(wr_addr), 64'd0);
    chk("ar_data",   64'(wr_data), 64'd0);
    idle();
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1;
    ex_valid = 1; ex_rd = 5'd4; ex_data = 32'h44;
    ld_valid = 1; ld_rd = 5'd3; ld_data = 32'h33;
    step("ar_after");
    chk("ar_after_ld_first", 64'(last_ld_hs), 64'd1);
    idle();

    // Random traffic with producers holding until accepted
    last_ex_hs = 1; last_ld_hs = 1;
    for (int i = 0; i < 400; i++) begin
      if (!ex_valid || last_ex_hs) begin
        ex_valid = ($urandom % 3) != 0;
        ex_rd = 5'($urandom_range(0, 31));
        ex_data = $urandom;
      end
      if (!ld_valid || last_ld_hs) begin
        ld_valid = ($urandom % 2) != 0;
        ld_rd = 5'($urandom_range(0, 31));
        ld_data = $urandom;
      end
      issue_valid = ($urandom % 2) != 0;
      issue_rd = 5'($urandom_range(0, 31));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
Writeback stage that drives the register file's single write port. It arbitrates between the execute-result channel and the load-result channel, and registers the winning result onto the write port. It keeps a per-register pending scoreboard for the issue stage. It also supplies a one-cycle bypass, because the register file's registered read returns stale data for a same-cycle write.

Parameters:
XW, 32, register/data width in bits
CW, 32, width of retire counter

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, asynchronous, active-low
i_ex_valid  input  1  execute result valid
o_ex_ready  output  1  execute result accepted this cycle
i_ex_rd  input  5  execute destination register
i_ex_data  input  XW  execute result
i_ld_valid  input  1  load result valid
o_ld_ready  output  1  load result accepted this cycle
i_ld_rd  input  5  load destination register
i_ld_data  input  XW  load data
i_issue_valid  input  1  instruction issued with destination i_issue_rd
i_issue_rd  input  5  issued destination register
o_busy  output  32  pending-write bitmap, bit r = xr awaiting result
o_wr_en  output  1  register file write enable
o_wr_addr  output  5  register file write address
o_wr_data  output  XW  register file write data
o_byp_valid  output  1  bypass entry valid
o_byp_addr  output  5  bypass register address
o_byp_data  output  XW  bypass data
o_retire_cnt  output  CW  count of accepted results

Behaviour:
- Reset (async, any time, including mid-transfer) clears all outputs and state to 0:
  - o_wr_en/addr/data, o_byp_*, o_busy, o_retire_cnt, the last_grant bit.
  - In-flight handshakes are dropped.
- Arbitration (combinational, ready may depend on valid; valid must not depend on ready):
  - Only one valid: that channel is granted.
  - Both valid: grant goes opposite to last_grant. last_grant resets to EX, so load wins the first contention.
  - last_grant updates only on a contended cycle, to the channel granted.
  - o_x_ready = grant_x; at most one ready high per cycle.
  - A producer holds valid/rd/data stable until ready.
- Handshake = valid & ready. On a handshake cycle N, at edge N+1:
  - o_wr_en = (rd != 0), o_wr_addr = rd, o_wr_data = data. Latency is one cycle.
  - With no handshake, o_wr_en = 0. Addr/data hold their previous values.
- Writes to x0 are accepted (ready high, counted) but never assert o_wr_en.
- Bypass: at each edge, o_byp_valid/addr/data <= o_wr_en/addr/data. The bypass is the write that landed during the cycle in which the consumer's read address was sampled. Consumers substitute o_byp_data when o_byp_valid and o_byp_addr matches their read address.
- Scoreboard, evaluated per bit r at each edge:
  - set_r = i_issue_valid & i_issue_rd == r.
  - clr_r = a handshake with rd == r.
  - Set wins over clear (a newer instruction is pending).
  - o_busy[0] is always 0.
  - A clear with no busy bit set is legal and has no effect.
- o_retire_cnt increments by 1 per handshake (x0 included). It wraps modulo 2^CW with no saturation.
- Simultaneous ex and ld results to the same rd on a contended cycle: serialized by arbitration; the later grant's data is final.

Test Plan:
- Single ex result: ex_valid, rd=5, data=0xDEADBEEF at cycle 0 -> ex_ready=1 at cycle 0; wr_en=1, addr=5, data=0xDEADBEEF at cycle 1; byp_valid=1, addr=5 at cycle 2; retire_cnt=1.
- Contention: both valid, held for 4 cycles (ld rd=3, ex rd=4), from reset -> grant order ld, ex, ld, ex; wr_addr sequence 3, 4, 3, 4; never both ready in the same cycle.
- x0 write: ex rd=0, data=0x1234 -> ex_ready=1; wr_en stays 0; retire_cnt increments; busy[0]=0.
- Scoreboard: issue rd=7 at cycle 0 -> busy[7]=1 at cycle 1. Ex result rd=7 with issue rd=7 in the same cycle -> busy[7] stays 1. Result rd=7 alone later -> busy[7]=0 next cycle.
- Counter wrap: CW=4, 17 handshakes -> retire_cnt=1.
- Reset mid-operation: assert i_rst_n=0 asynchronously while wr_en=1 and busy=0x00000080 -> all outputs 0 immediately, without waiting for a clock edge. After release, the first contended cycle grants ld.
